wrr_mux_arbiter: RTL
====================

Name: wrr_mux_arbiter

Overview:
- Weighted round-robin arbiter that produces the one-hot select for the CHANNELS-input, WIDTH-bit data mux.
- Shares the mux output between CHANNELS requesters. Each channel holds the grant for up to its programmed weight in consecutive cycles, then priority rotates to the next channel.
- The selOneHot output connects directly to the mux select input. grantValid and grantIdx are provided for downstream consumers of dataOut.

Parameters:
- CHANNELS, 8, number of requesters and mux inputs.
- WT_WIDTH, 4, bits per channel weight field.
- IDX_WIDTH, 3, width of grantIdx. Must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  CHANNELS  per-channel request; bit k = channel k.
- wtBus  input  CHANNELS*WT_WIDTH  per-channel weights; channel k occupies bits [k*WT_WIDTH +: WT_WIDTH].
- selOneHot  output  CHANNELS  registered one-hot grant to the mux select; all-zero when idle.
- grantValid  output  1  high when selOneHot is non-zero.
- grantIdx  output  IDX_WIDTH  binary index of the granted channel; 0 when idle.
- creditLeft  output  WT_WIDTH  cycles remaining in the current grant after the present one.

Behaviour:
- One clock domain and a synchronous, active-high reset are already decided. Reset is sampled only on the clk rising edge.
- Reset values: selOneHot=0, grantValid=0, grantIdx=0, creditLeft=0, rotation pointer ptr=0, state=IDLE.
- Reset asserted mid-grant: all outputs are zero after that edge; after reset releases, arbitration restarts from ptr=0.
- All outputs are registered. A request sampled at edge N produces a grant visible after edge N (one-cycle latency).
- Winner selection: the first channel with req high, searching circularly from ptr upward, wrapping from CHANNELS-1 to 0.
- Effective weight: w = wtBus field, with a field value of 0 treated as 1. The weight is latched at grant time; wtBus changes during a grant are ignored until the next grant.
- State IDLE:
  - If req==0, remain in IDLE with outputs zero.
  - Otherwise grant the winner g: selOneHot=1<<g, grantIdx=g, grantValid=1, creditLeft=w(g)-1. Go to GRANT.
- State GRANT (current grant g), evaluated at each edge:
  - If req[g]=1 and creditLeft>0: hold the grant and decrement creditLeft.
  - Otherwise (credit exhausted or req[g] dropped): set ptr=(g+1) mod CHANNELS and re-arbitrate in the same edge.
    - If a winner exists, switch directly to it with fresh credit; there is no idle bubble between grants.
    - If g is the only requester, g is re-granted with fresh credit.
    - If no requests remain, go to IDLE, outputs zero, ptr keeps the updated value.
- A grant is only ever issued to a channel whose req was high at the issuing edge. A channel that drops req loses the grant at the next edge.
- Invariant: selOneHot is either zero or exactly one-hot, and grantIdx always matches it.
- Fairness: with all channels requesting, the service order is 0,1,...,CHANNELS-1, repeated. Each channel k receives w(k) consecutive cycles per round, and the round period equals the sum of w.
- Requests arriving on a non-granted channel do not pre-empt the current grant.

Test Plan:
- Reset, then req=0 for 5 cycles -> selOneHot=0, grantValid=0, grantIdx=0, creditLeft=0 throughout.
- Weights ch k = k+1, req=8'hFF held -> grants ch0 x1, ch1 x2, ... ch7 x8 with no gaps, period 36 cycles, repeating. Check selOneHot is one-hot every cycle.
- Only req[3]=1, weight 4 -> ch3 granted continuously. creditLeft counts 3,2,1,0,3,2,... with no drop in grantValid.
- Weight field 0 on ch2, req=8'b0000_0110 -> alternation ch1 (weight 2) x2, ch2 x1. Weight 0 behaves as 1.
- req=8'h81, weights ch0=3, ch7=2, ptr forced to 7 by first granting ch7 alone -> ch7 x2, ch0 x3, ch7 x2. Confirms wrap-around 7->0.
- ch5 granted with weight 6; deassert req[5] after 2 cycles while req[6]=1 -> ch6 granted on the following edge. Then assert reset mid-grant -> all outputs 0 next cycle, and the first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/wrr_mux_arbiter_if.sv
// Request/weight/grant bundle between requesters and the weighted round-robin arbiter.
// The arbiter takes the slave view; the requester side takes the master view.
interface wrr_mux_arbiter_if #(
  parameter int CHANNELS  = 8,
  parameter int WT_WIDTH  = 4,
  parameter int IDX_WIDTH = 3
);
  logic [CHANNELS-1:0]          req;
  logic [CHANNELS*WT_WIDTH-1:0] wtBus;
  logic [CHANNELS-1:0]          selOneHot;
  logic                         grantValid;
  logic [IDX_WIDTH-1:0]         grantIdx;
  logic [WT_WIDTH-1:0]          creditLeft;

  modport master (
    output req,
    output wtBus,
    input  selOneHot,
    input  grantValid,
    input  grantIdx,
    input  creditLeft
  );

  modport slave (
    input  req,
    input  wtBus,
    output selOneHot,
    output grantValid,
    output grantIdx,
    output creditLeft
  );
endinterface

// File: rtl/wrr_mux_arbiter.sv
// Weighted round-robin arbiter driving the one-hot select of a CHANNELS-input data mux.
// A channel keeps the grant for up to its latched weight in cycles, then priority rotates past it.
module wrr_mux_arbiter #(
  parameter int CHANNELS  = 8,
  parameter int WT_WIDTH  = 4,
  parameter int IDX_WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  wrr_mux_arbiter_if.slave   arb_if
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [CHANNELS-1:0]   sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [WT_WIDTH-1:0]   credit_q, credit_d;

  logic                  hold_s;
  logic [IDX_WIDTH-1:0]  base_s;
  logic                  win_found_s;
  logic [IDX_WIDTH-1:0]  win_idx_s;
  logic [WT_WIDTH-1:0]   win_field_s;

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
    if (int'(i) == CHANNELS - 1) begin
      return '0;
    end else begin
      return i + IDX_WIDTH'(1);
    end
  endfunction

  // A zero weight field behaves as weight 1, so its credit after the first cycle is 0.
  function automatic logic [WT_WIDTH-1:0] first_credit(input logic [WT_WIDTH-1:0] field);
    if (field == '0) begin
      return '0;
    end else begin
      return field - WT_WIDTH'(1);
    end
  endfunction

  function automatic void pick_winner(
    input  logic [CHANNELS-1:0]  r,
    input  logic [IDX_WIDTH-1:0] base,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
  );
    logic [IDX_WIDTH-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = base;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
      cand = next_idx(cand);
    end
  endfunction

  // Circular search for the next winner; in GRANT the search starts just past the holder.
  always_comb begin
    hold_s      = (state_q == ST_GRANT) && arb_if.req[idx_q] && (credit_q != '0);
    base_s      = (state_q == ST_GRANT) ? next_idx(idx_q) : ptr_q;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    pick_winner(arb_if.req, base_s, win_found_s, win_idx_s);
    win_field_s = arb_if.wtBus[win_idx_s*WT_WIDTH +: WT_WIDTH];
  end

  // Next-state and next-output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    credit_d = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d  = ST_GRANT;
          idx_d    = win_idx_s;
          sel_d    = CHANNELS'(1) << win_idx_s;
          valid_d  = 1'b1;
          credit_d = first_credit(win_field_s);
        end else begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          sel_d    = '0;
          valid_d  = 1'b0;
          credit_d = '0;
        end
      end
      ST_GRANT: begin
        if (hold_s) begin
          credit_d = credit_q - WT_WIDTH'(1);
        end else begin
          // Rotation point moves past the releasing channel whether or not anyone wins.
          ptr_d = base_s;
          if (win_found_s) begin
            state_d  = ST_GRANT;
            idx_d    = win_idx_s;
            sel_d    = CHANNELS'(1) << win_idx_s;
            valid_d  = 1'b1;
            credit_d = first_credit(win_field_s);
          end else begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            sel_d    = '0;
            valid_d  = 1'b0;
            credit_d = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ptr_d    = '0;
        idx_d    = '0;
        sel_d    = '0;
        valid_d  = 1'b0;
        credit_d = '0;
      end
    endcase
  end

  // State, rotation pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      credit_q <= credit_d;
    end
  end

  assign arb_if.selOneHot  = sel_q;
  assign arb_if.grantValid = valid_q;
  assign arb_if.grantIdx   = idx_q;
  assign arb_if.creditLeft = credit_q;

endmodule
